uart_rx_capture: RTL and testbench

// - 8N1 UART receiver with byte FIFO. Consumes the SoC uart_tx serial line (out_uart_tx of top_top).
// - Delivers received bytes on a valid/ready stream to an on-chip checker or log sink.
// - Replaces behavioural UART monitoring for synthesizable/emulation self-checking flows.

---
 rtl/uart_rx_capture_pkg.sv | 8 +
 rtl/uart_rx_capture_fifo.sv | 51 +++++
 rtl/uart_rx_capture.sv | 133 +++++++++++++
 tb/tb_uart_rx_capture.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_capture_pkg.sv
// uart_rx_capture_pkg: shared states, constants and baud divisor helper
package uart_rx_capture_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
  localparam int UART_DATA_BITS = 8;
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_capture_fifo.sv
// uart_rx_capture_fifo: synchronous first-word-fall-through byte FIFO
module uart_rx_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic                       in_push,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_pop,
  input  logic                       in_clear,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     out_level,
  output logic                       out_full,
  output logic                       out_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             w_pop;
  logic             w_push;
  assign out_full  = r_level == LW'(DEPTH);
  assign out_empty = r_level == '0;
  assign w_pop     = in_pop && !out_empty;
  assign w_push    = in_push && (!out_full || w_pop);
  assign out_level = r_level;
  assign out_data  = out_empty ? '0 : r_mem[r_rd];
  // pointers and occupancy; clear wins over any same-cycle push/pop
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (in_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
  // storage array, written only for accepted pushes
  always_ff @(posedge in_clk) begin
    if (w_push && !in_clear) r_mem[r_wr] <= in_data;
  end
endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 8N1 UART receiver feeding a valid/ready byte FIFO
module uart_rx_capture
  import uart_rx_capture_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 781250,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic                          in_uart_rx,
  input  logic                          in_rx_en,
  input  logic                          in_clear,
  output logic [UART_DATA_BITS-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   out_level,
  output logic                          out_frame_err,
  output logic                          out_overflow
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(UART_DATA_BITS);
  if (DIV < 4) begin : g_bad_div
    $error("uart_rx_capture: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_capture: FIFO_DEPTH must be a power of two >= 2");
  end
  logic [1:0]                r_sync;
  logic                      w_rx_s;
  rx_state_e                 r_state;
  rx_state_e                 w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [BW-1:0]             r_bit;
  logic [BW-1:0]             w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      w_push;
  logic                      w_ferr;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      r_frame_err;
  logic                      r_overflow;
  assign w_rx_s        = r_sync[1];
  assign out_valid     = !w_empty;
  assign w_pop         = out_valid && in_ready;
  assign out_frame_err = r_frame_err;
  assign out_overflow  = r_overflow;
  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], in_uart_rx};
  end
  // receiver state, baud counter, bit index and shift register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end
  // next-state: start is checked mid-bit, data and stop one full bit later each
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s && in_rx_en) w_state_nxt = START;
      end
      START: if (r_cnt == CW'(DIV / 2 - 1)) begin
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = w_rx_s ? IDLE : DATA;
      end
      DATA: if (r_cnt == CW'(DIV - 1)) begin
        w_cnt_nxt   = '0;
        w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
        w_bit_nxt   = r_bit + 1'b1;
        if (r_bit == BW'(UART_DATA_BITS - 1)) w_state_nxt = STOP;
      end
      STOP: if (r_cnt == CW'(DIV - 1)) begin
        w_cnt_nxt   = '0;
        w_push      = w_rx_s;
        w_ferr      = !w_rx_s;
        w_state_nxt = w_rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // frame-error pulse and sticky overflow; clear drops overflow
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overflow  <= in_clear ? 1'b0 : (w_push && w_full && !w_pop) ? 1'b1 : r_overflow;
    end
  end
  uart_rx_capture_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .in_push  (w_push),
    .in_data  (r_shift),
    .in_pop   (w_pop),
    .in_clear (in_clear),
    .out_data (out_data),
    .out_level(out_level),
    .out_full (w_full),
    .out_empty(w_empty)
  );
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed checks of the UART receiver and its FIFO
module tb_uart_rx_capture;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_en = 1'b1;
  logic       clr = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] level;
  logic       ferr;
  logic       ovf;
  int         tests = 0;
  int         fails = 0;
  int         ferr_total = 0;
  int         ferr_before;
  int         rise_at;

  always #5 clk = ~clk;

  always @(negedge clk) if (ferr) ferr_total++;

  uart_rx_capture dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .in_uart_rx   (rx),
    .in_rx_en     (rx_en),
    .in_clear     (clr),
    .out_data     (data),
    .out_valid    (valid),
    .in_ready     (ready),
    .out_level    (level),
    .out_frame_err(ferr),
    .out_overflow (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one frame, 32 clocks per bit; index 0 is the first edge seeing the start bit
  task automatic send(input logic [7:0] b, input logic stop, input int extra, input int pop_at);
    logic [9:0] fr;
    logic       pv;
    fr = {stop, b, 1'b0};
    rise_at = -1;
    pv = valid;
    for (int i = 0; i < (10 + extra) * 32; i++) begin
      rx = (i / 32 < 10) ? fr[i / 32] : stop;
      ready = (i == pop_at);
      @(posedge clk);
      #1;
      if (valid && !pv && rise_at < 0) rise_at = i;
      pv = valid;
    end
    ready = 1'b0;
    rx = 1'b1;
  endtask

  task automatic pop_one;
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    idle(5);

    send(8'h65, 1'b1, 0, -1);
    chk("b65_latency", 32'(rise_at), 306);
    chk("b65_valid", 32'(valid), 1);
    chk("b65_data", 32'(data), 32'h65);
    chk("b65_level", 32'(level), 1);
    chk("b65_ferr", 32'(ferr_total), 0);
    pop_one();
    chk("b65_popped_valid", 32'(valid), 0);
    chk("b65_popped_level", 32'(level), 0);

    rx = 1'b0;
    idle(8);
    rx = 1'b1;
    idle(400);
    chk("glitch_level", 32'(level), 0);
    chk("glitch_ferr", 32'(ferr_total), 0);

    rx_en = 1'b0;
    send(8'h11, 1'b1, 0, -1);
    idle(10);
    chk("rxen_off_level", 32'(level), 0);
    rx_en = 1'b1;

    send(8'hA5, 1'b0, 3, -1);
    chk("ferr_pulse", 32'(ferr_total), 1);
    chk("ferr_level", 32'(level), 0);
    idle(400);
    chk("ferr_no_restart_cnt", 32'(ferr_total), 1);
    chk("ferr_no_restart_level", 32'(level), 0);

    for (int b = 0; b < 8; b++) send(8'(b), 1'b1, 0, -1);
    chk("fill_level", 32'(level), 8);
    chk("fill_ovf", 32'(ovf), 0);
    send(8'h08, 1'b1, 0, -1);
    chk("ovf_level", 32'(level), 8);
    chk("ovf_set", 32'(ovf), 1);
    for (int k = 0; k < 8; k++) begin
      chk("ovf_drain", 32'(data), 32'(k));
      pop_one();
    end
    chk("ovf_drain_empty", 32'(valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("clear_ovf", 32'(ovf), 0);
    chk("clear_level", 32'(level), 0);

    for (int b = 0; b < 8; b++) send(8'h10 + 8'(b), 1'b1, 0, -1);
    chk("full_level", 32'(level), 8);
    send(8'h5A, 1'b1, 0, 306);
    chk("pushpop_ovf", 32'(ovf), 0);
    chk("pushpop_level", 32'(level), 8);
    for (int k = 0; k < 8; k++) begin
      chk("pushpop_drain", 32'(data), k < 7 ? 32'h11 + 32'(k) : 32'h5A);
      pop_one();
    end
    chk("pushpop_empty", 32'(valid), 0);

    ferr_before = ferr_total;
    for (int i = 0; i < 32 * 5 + 16; i++) begin
      rx = (i < 32) ? 1'b0 : 1'b0;
      idle(1);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    idle(3);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_level", 32'(level), 0);
    rst_n = 1'b1;
    idle(5);
    send(8'h3C, 1'b1, 0, -1);
    chk("b3c_latency", 32'(rise_at), 306);
    chk("b3c_data", 32'(data), 32'h3C);
    chk("b3c_level", 32'(level), 1);
    chk("b3c_ovf", 32'(ovf), 0);
    chk("b3c_ferr", 32'(ferr_total - ferr_before), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
